// File: rtl/deal_sequencer.sv
// Paced blackjack dealing controller: synchronises the game clock into ticks, fetches cards
// over req/ack, tracks both hands with soft-ace totals and plays the dealer's draw-to-17 rule.
module deal_sequencer #(
  parameter int TICKS_PER_CARD = 2,
  parameter int CARD_W         = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              div_clk,
  input  logic              start,
  input  logic              hit,
  input  logic              stand,
  input  logic              card_ack,
  input  logic [CARD_W-1:0] card_value,
  output logic              card_req,
  output logic              deal_valid,
  output logic              deal_target,
  output logic [CARD_W-1:0] deal_card,
  output logic [4:0]        player_total,
  output logic [4:0]        dealer_total,
  output logic              player_bust,
  output logic              dealer_bust,
  output logic              busy,
  output logic [2:0]        phase
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_WAIT, S_INIT_REQ, S_PLAYER, S_P_WAIT, S_P_REQ, S_D_WAIT, S_D_REQ, S_DONE
  } state_t;

  localparam logic [3:0] TICK_TARGET = 4'(TICKS_PER_CARD);

  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  function automatic state_t dealer_entry(input logic [4:0] dealer_best);
    return (dealer_best >= 5'd17) ? S_DONE : S_D_WAIT;
  endfunction

  function automatic logic [2:0] phase_of(input state_t s);
    case (s)
      S_INIT_WAIT, S_INIT_REQ: return 3'd1;
      S_PLAYER:                return 3'd2 + 3'd1;
      S_P_WAIT, S_P_REQ:       return 3'd4;
      S_D_WAIT, S_D_REQ:       return 3'd5;
      S_DONE:                  return 3'd6;
      default:                 return 3'd0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [4:0]        p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic              p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic              card_req_q, card_req_d;
  logic              deal_valid_q, deal_valid_d;
  logic              deal_target_q, deal_target_d;
  logic [CARD_W-1:0] deal_card_q, deal_card_d;
  logic [4:0]        player_total_q, player_total_d, dealer_total_q, dealer_total_d;
  logic              player_bust_q, player_bust_d, dealer_bust_q, dealer_bust_d;
  logic              busy_q, busy_d;
  logic [2:0]        phase_q, phase_d;
  logic              div_s1_q, div_s2_q, div_prev_q;

  logic       tick, rank_ok, is_ace, accept, to_dealer;
  logic [4:0] pts, p_best_new, d_best_new;

  assign tick    = div_s2_q & ~div_prev_q;
  assign rank_ok = (card_value != '0) && (card_value <= CARD_W'(13));
  assign is_ace  = (card_value == CARD_W'(1));
  assign pts     = (card_value >= CARD_W'(10)) ? 5'd10 : 5'(card_value);
  assign accept  = card_req_q & card_ack & rank_ok;
  assign to_dealer = (state_q == S_D_REQ) || ((state_q == S_INIT_REQ) && idx_q[0]);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    p_hard_d      = p_hard_q;
    p_ace_d       = p_ace_q;
    d_hard_d      = d_hard_q;
    d_ace_d       = d_ace_q;
    card_req_d    = card_req_q;
    deal_valid_d  = 1'b0;
    deal_target_d = deal_target_q;
    deal_card_d   = deal_card_q;

    if (accept) begin
      deal_valid_d  = 1'b1;
      deal_target_d = to_dealer;
      deal_card_d   = card_value;
      card_req_d    = 1'b0;
      if (to_dealer) begin
        d_hard_d = d_hard_q + pts;
        d_ace_d  = d_ace_q | is_ace;
      end else begin
        p_hard_d = p_hard_q + pts;
        p_ace_d  = p_ace_q | is_ace;
      end
    end
    p_best_new = best_total(p_hard_d, p_ace_d);
    d_best_new = best_total(d_hard_d, d_ace_d);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          p_hard_d = '0;
          p_ace_d  = 1'b0;
          d_hard_d = '0;
          d_ace_d  = 1'b0;
          idx_d    = '0;
          state_d  = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT, S_P_WAIT, S_D_WAIT: begin
        if (cnt_q == TICK_TARGET) begin
          card_req_d = 1'b1;
          state_d    = (state_q == S_INIT_WAIT) ? S_INIT_REQ :
                       (state_q == S_P_WAIT)    ? S_P_REQ    : S_D_REQ;
        end else if (tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_INIT_REQ: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            state_d = (p_best_new == 5'd21) ? dealer_entry(d_best_new) : S_PLAYER;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_INIT_WAIT;
          end
        end
      end
      S_PLAYER: begin
        if (stand)    state_d = dealer_entry(d_best_new);
        else if (hit) state_d = S_P_WAIT;
      end
      S_P_REQ: begin
        if (accept) begin
          if (p_best_new > 5'd21)       state_d = S_DONE;
          else if (p_best_new == 5'd21) state_d = dealer_entry(d_best_new);
          else                          state_d = S_PLAYER;
        end
      end
      S_D_REQ: begin
        if (accept) state_d = dealer_entry(d_best_new);
      end
      default: state_d = S_IDLE;
    endcase

    // Pacing restarts from zero whenever a wait state is freshly entered.
    if ((state_d != state_q) &&
        (state_d == S_INIT_WAIT || state_d == S_P_WAIT || state_d == S_D_WAIT)) begin
      cnt_d = '0;
    end

    player_total_d = best_total(p_hard_d, p_ace_d);
    dealer_total_d = best_total(d_hard_d, d_ace_d);
    player_bust_d  = (player_total_d > 5'd21);
    dealer_bust_d  = (dealer_total_d > 5'd21);
    busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
    phase_d        = phase_of(state_d);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      p_hard_q       <= '0;
      p_ace_q        <= 1'b0;
      d_hard_q       <= '0;
      d_ace_q        <= 1'b0;
      card_req_q     <= 1'b0;
      deal_valid_q   <= 1'b0;
      deal_target_q  <= 1'b0;
      deal_card_q    <= '0;
      player_total_q <= '0;
      dealer_total_q <= '0;
      player_bust_q  <= 1'b0;
      dealer_bust_q  <= 1'b0;
      busy_q         <= 1'b0;
      phase_q        <= '0;
      div_s1_q       <= 1'b0;
      div_s2_q       <= 1'b0;
      div_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      p_hard_q       <= p_hard_d;
      p_ace_q        <= p_ace_d;
      d_hard_q       <= d_hard_d;
      d_ace_q        <= d_ace_d;
      card_req_q     <= card_req_d;
      deal_valid_q   <= deal_valid_d;
      deal_target_q  <= deal_target_d;
      deal_card_q    <= deal_card_d;
      player_total_q <= player_total_d;
      dealer_total_q <= dealer_total_d;
      player_bust_q  <= player_bust_d;
      dealer_bust_q  <= dealer_bust_d;
      busy_q         <= busy_d;
      phase_q        <= phase_d;
      div_s1_q       <= div_clk;
      div_s2_q       <= div_s1_q;
      div_prev_q     <= div_s2_q;
    end
  end

  assign card_req     = card_req_q;
  assign deal_valid   = deal_valid_q;
  assign deal_target  = deal_target_q;
  assign deal_card    = deal_card_q;
  assign player_total = player_total_q;
  assign dealer_total = dealer_total_q;
  assign player_bust  = player_bust_q;
  assign dealer_bust  = dealer_bust_q;
  assign busy         = busy_q;
  assign phase        = phase_q;

endmodule
